// File: rtl/conv_window_gen_pkg.sv
// Shared types and default geometry for the 3x3 window generator.
package conv_pkg;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);

    // IDLE: waiting for a frame, FILL: rows 0..1 loading, STREAM: windows emitted
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bus of the window generator.
// Handshake: a pixel is consumed in every cycle pix_valid=1 (no ready, no
// backpressure); clear drops any pixel presented with it. win_valid=1 marks
// a cycle where win_1..win_9 hold a new window that must be taken that cycle,
// and frame_done pulses together with the last window of a frame.
interface conv_window_gen_if #(
    parameter int DATA_W = conv_pkg::DATA_W
);
    logic              clear;
    logic              pix_valid;
    logic [DATA_W-1:0] pix_in;
    logic              win_valid;
    logic              frame_done;
    logic [DATA_W-1:0] win_1, win_2, win_3;
    logic [DATA_W-1:0] win_4, win_5, win_6;
    logic [DATA_W-1:0] win_7, win_8, win_9;

    modport master (
        output clear, pix_valid, pix_in,
        input  win_valid, frame_done,
        input  win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9
    );

    modport slave (
        input  clear, pix_valid, pix_in,
        output win_valid, frame_done,
        output win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9
    );
endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of delay: dout is the pixel accepted DEPTH enables ago.
module line_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Shift register advancing only on accepted pixels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream -> every fully-valid 3x3 window, one cycle latency.
module conv_window_gen #(
    parameter int IMG_W  = conv_pkg::IMG_W,
    parameter int IMG_H  = conv_pkg::IMG_H,
    parameter int DATA_W = conv_pkg::DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    conv_window_gen_if.slave bus,
    output conv_pkg::state_t state
);
    import conv_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              win_valid_q;
    logic              frame_done_q;
    logic [DATA_W-1:0] win_q [9];
    logic [DATA_W-1:0] row1_pix;   // same column, previous row
    logic [DATA_W-1:0] row2_pix;   // same column, two rows up
    // Columns c-2 and c-1 of each of the three window rows
    logic [DATA_W-1:0] top_sr [2];
    logic [DATA_W-1:0] mid_sr [2];
    logic [DATA_W-1:0] bot_sr [2];

    logic accept, col_last, frame_last, emit;

    assign accept     = bus.pix_valid && !bus.clear;
    assign col_last   = (col == COL_LAST);
    assign frame_last = col_last && (row == ROW_LAST);
    // Columns 0..1 never emit, so the column shift regs are always refilled
    // from the current row before a window is formed
    assign emit       = accept && (state == STREAM) && (col >= CW'(2));

    line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb_row1 (
        .clk(clk), .rst_n(rst_n), .en(accept), .din(bus.pix_in), .dout(row1_pix)
    );

    line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb_row2 (
        .clk(clk), .rst_n(rst_n), .en(accept), .din(row1_pix), .dout(row2_pix)
    );

    // Column shift of the three window rows on each accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                top_sr[i] <= '0;
                mid_sr[i] <= '0;
                bot_sr[i] <= '0;
            end
        end else if (accept) begin
            top_sr[0] <= top_sr[1];
            top_sr[1] <= row2_pix;
            mid_sr[0] <= mid_sr[1];
            mid_sr[1] <= row1_pix;
            bot_sr[0] <= bot_sr[1];
            bot_sr[1] <= bus.pix_in;
        end
    end

    // Position counters, frame FSM and registered window outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else if (bus.clear) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            win_valid_q  <= emit;
            frame_done_q <= emit && frame_last;
            if (emit) begin
                win_q[0] <= top_sr[0];
                win_q[1] <= top_sr[1];
                win_q[2] <= row2_pix;
                win_q[3] <= mid_sr[0];
                win_q[4] <= mid_sr[1];
                win_q[5] <= row1_pix;
                win_q[6] <= bot_sr[0];
                win_q[7] <= bot_sr[1];
                win_q[8] <= bus.pix_in;
            end
            if (bus.pix_valid) begin
                col <= col_last ? '0 : col + 1'b1;
                if (col_last) row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                case (state)
                    IDLE:    state <= FILL;
                    FILL:    if (col_last && row == RW'(1)) state <= STREAM;
                    STREAM:  if (frame_last) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.win_1 = win_q[0];
    assign bus.win_2 = win_q[1];
    assign bus.win_3 = win_q[2];
    assign bus.win_4 = win_q[3];
    assign bus.win_5 = win_q[4];
    assign bus.win_6 = win_q[5];
    assign bus.win_7 = win_q[6];
    assign bus.win_8 = win_q[7];
    assign bus.win_9 = win_q[8];

endmodule
